// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake between an instruction source and the ALU sequencer.
// The word is packed as {op[1:0], rd, rs, rt}.
interface alu_seq_ctrl_if #(
   parameter int AW = 3
);
   logic                instr_valid;
   logic                instr_ready;
   logic [2+3*AW-1:0]   instr;

   modport master (
      output instr_valid,
      output instr,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr,
      output instr_ready
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Three-cycle register-register sequencer in front of a combinational 16-bit ALU.
// It owns the register file, drives ALU operands in EXEC and writes the result back in WB.
//
// state | meaning
// IDLE  | ready for an instruction; external register writes honoured here only
// EXEC  | operands presented to the ALU; result and carry captured
// WB    | done pulse; captured result written to reg[rd] at the end of the cycle
module alu_seq_ctrl #(
   parameter int W    = 16,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic            i_clk,
   input  logic            i_reset,
   alu_seq_ctrl_if.slave   if_instr,
   input  logic            i_wr_en,
   input  logic [AW-1:0]   i_wr_addr,
   input  logic [W-1:0]    i_wr_data,
   input  logic [AW-1:0]   i_rd_addr,
   output logic [W-1:0]    o_rd_data,
   output logic [1:0]      o_alu_op,
   output logic [W-1:0]    o_alu_a,
   output logic [W-1:0]    o_alu_b,
   input  logic [W-1:0]    i_alu_o,
   input  logic            i_alu_cout,
   output logic            o_done,
   output logic [W-1:0]    o_result,
   output logic            o_carry
);

   localparam int IW = 2 + 3*AW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t           r_state;
   logic [W-1:0]     r_regs [NREG];
   logic [AW-1:0]    r_rd;
   logic [1:0]       r_alu_op;
   logic [W-1:0]     r_alu_a;
   logic [W-1:0]     r_alu_b;
   logic             r_done;
   logic [W-1:0]     r_result;
   logic             r_carry;

   logic [1:0]       w_op;
   logic [AW-1:0]    w_rd;
   logic [AW-1:0]    w_rs;
   logic [AW-1:0]    w_rt;
   logic             w_ready;
   logic             w_accept;

   assign w_op = if_instr.instr[IW-1 -: 2];
   assign w_rd = if_instr.instr[3*AW-1 -: AW];
   assign w_rs = if_instr.instr[2*AW-1 -: AW];
   assign w_rt = if_instr.instr[AW-1:0];

   // Gated by reset so nothing can be accepted while the block is being cleared.
   assign w_ready  = (r_state == ST_IDLE) && !i_reset;
   assign w_accept = if_instr.instr_valid && w_ready;

   assign if_instr.instr_ready = w_ready;
   assign o_rd_data = r_regs[i_rd_addr];
   assign o_alu_op  = r_alu_op;
   assign o_alu_a   = r_alu_a;
   assign o_alu_b   = r_alu_b;
   assign o_done    = r_done;
   assign o_result  = r_result;
   assign o_carry   = r_carry;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_rd     <= '0;
         r_alu_op <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_carry  <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_wr_en) begin
                  r_regs[i_wr_addr] <= i_wr_data;
               end
               // Operand registers double as the ALU drive, so they hold outside EXEC.
               if (w_accept) begin
                  r_alu_op <= w_op;
                  r_rd     <= w_rd;
                  r_alu_a  <= r_regs[w_rs];
                  r_alu_b  <= r_regs[w_rt];
                  r_state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_result <= i_alu_o;
               r_carry  <= r_alu_op[1] ? 1'b0 : i_alu_cout;
               r_done   <= 1'b1;
               r_state  <= ST_WB;
            end
            ST_WB: begin
               r_regs[r_rd] <= r_result;
               r_done       <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 16-bit ALU attached.
module tb_alu_seq_ctrl;

   logic          clk_sys;
   logic          reset;
   logic          wr_en;
   logic [2:0]    wr_addr;
   logic [15:0]   wr_data;
   logic [2:0]    rd_addr;
   logic [15:0]   rd_data;
   logic [1:0]    alu_op;
   logic [15:0]   alu_a;
   logic [15:0]   alu_b;
   logic [15:0]   alu_o;
   logic          alu_cout;
   logic          done;
   logic [15:0]   result;
   logic          carry;

   int n_chk  = 0;
   int n_pass = 0;

   alu_seq_ctrl_if #(.AW(3)) u_if ();

   alu_seq_ctrl #(.W(16), .NREG(8), .AW(3)) u_dut (
      .i_clk      (clk_sys),
      .i_reset    (reset),
      .if_instr   (u_if),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data),
      .o_alu_op   (alu_op),
      .o_alu_a    (alu_a),
      .o_alu_b    (alu_b),
      .i_alu_o    (alu_o),
      .i_alu_cout (alu_cout),
      .o_done     (done),
      .o_result   (result),
      .o_carry    (carry)
   );

   // The logic ops report cout=1 so the sequencer's carry masking is visible.
   always_comb begin
      logic [16:0] sum;
      sum = 17'd0;
      case (alu_op)
         2'b00: sum = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
         2'b10: sum = {1'b1, alu_a & alu_b};
         default: sum = {1'b1, alu_a | alu_b};
      endcase
      alu_o    = sum[15:0];
      alu_cout = sum[16];
   end

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [10:0] mk(input logic [1:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt};
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic read_reg(input logic [2:0] addr, output logic [15:0] val);
      rd_addr = addr;
      #1;
      val = rd_data;
   endtask

   task automatic write_reg(input logic [2:0] addr, input logic [15:0] val);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = val;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic run_instr(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [2:0] rt, input logic [15:0] ea, input logic [15:0] eb,
                            input logic [15:0] eres, input logic ec, input logic [15:0] eold);
      logic [15:0] v;
      u_if.instr_valid = 1'b1;
      u_if.instr       = mk(op, rd, rs, rt);
      check("ready_before", 32'(u_if.instr_ready), 32'd1);
      tick();
      u_if.instr_valid = 1'b0;
      check("exec_op", 32'(alu_op), 32'(op));
      check("exec_a", 32'(alu_a), 32'(ea));
      check("exec_b", 32'(alu_b), 32'(eb));
      check("exec_ready", 32'(u_if.instr_ready), 32'd0);
      check("exec_done", 32'(done), 32'd0);
      tick();
      check("wb_done", 32'(done), 32'd1);
      check("wb_result", 32'(result), 32'(eres));
      check("wb_carry", 32'(carry), 32'(ec));
      read_reg(rd, v);
      check("wb_rd_old", 32'(v), 32'(eold));
      tick();
      check("post_done", 32'(done), 32'd0);
      check("post_ready", 32'(u_if.instr_ready), 32'd1);
      read_reg(rd, v);
      check("post_rd_new", 32'(v), 32'(eres));
   endtask

   initial begin
      logic [15:0] v;
      int n_done;
      reset = 1'b1;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      u_if.instr_valid = 1'b0;
      u_if.instr = '0;

      // reset state
      tick();
      tick();
      check("rst_ready_low", 32'(u_if.instr_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_ready_high", 32'(u_if.instr_ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      read_reg(3'd5, v);
      check("rst_r5", 32'(v), 32'd0);

      // add / sub
      write_reg(3'd1, 16'd5);
      write_reg(3'd2, 16'd3);
      run_instr(2'b00, 3'd3, 3'd1, 3'd2, 16'd5, 16'd3, 16'h0008, 1'b0, 16'h0000);
      run_instr(2'b01, 3'd4, 3'd2, 3'd1, 16'd3, 16'd5, 16'hFFFE, 1'b0, 16'h0000);
      run_instr(2'b01, 3'd5, 3'd1, 3'd2, 16'd5, 16'd3, 16'h0002, 1'b1, 16'h0000);

      // wraparound and logic ops
      write_reg(3'd6, 16'hFFFF);
      write_reg(3'd7, 16'h0001);
      run_instr(2'b00, 3'd0, 3'd6, 3'd7, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 16'h0000);
      run_instr(2'b10, 3'd0, 3'd6, 3'd7, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 16'h0000);
      run_instr(2'b11, 3'd0, 3'd6, 3'd1, 16'hFFFF, 16'h0005, 16'hFFFF, 1'b0, 16'h0001);

      // back-to-back r1 = r1 + r1 with valid held high
      n_done = 0;
      rd_addr = 3'd1;
      u_if.instr_valid = 1'b1;
      u_if.instr = mk(2'b00, 3'd1, 3'd1, 3'd1);
      for (int i = 0; i < 9; i++) begin
         check("b2b_ready", 32'(u_if.instr_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
         if (i == 3) check("b2b_r1_10", 32'(rd_data), 32'd10);
         if (i == 6) check("b2b_r1_20", 32'(rd_data), 32'd20);
         if (done) n_done++;
         tick();
         if (i == 6) u_if.instr_valid = 1'b0;
      end
      check("b2b_r1_40", 32'(rd_data), 32'd40);
      check("b2b_done_cnt", 32'(n_done), 32'd3);
      check("b2b_idle_ready", 32'(u_if.instr_ready), 32'd1);

      // reset while executing add r3,r1,r2
      u_if.instr_valid = 1'b1;
      u_if.instr = mk(2'b00, 3'd3, 3'd1, 3'd2);
      tick();
      u_if.instr_valid = 1'b0;
      check("rx_exec_a", 32'(alu_a), 32'd40);
      reset = 1'b1;
      #1;
      check("rx_ready_in_reset", 32'(u_if.instr_ready), 32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("rx_ready_after", 32'(u_if.instr_ready), 32'd1);
      check("rx_result", 32'(result), 32'd0);
      check("rx_alu_a", 32'(alu_a), 32'd0);
      n_done = 0;
      for (int i = 0; i < 3; i++) begin
         if (done) n_done++;
         tick();
      end
      check("rx_no_done", 32'(n_done), 32'd0);
      read_reg(3'd3, v);
      check("rx_r3", 32'(v), 32'd0);
      read_reg(3'd1, v);
      check("rx_r1", 32'(v), 32'd0);

      // wr_en outside IDLE is dropped
      write_reg(3'd1, 16'd5);
      write_reg(3'd2, 16'd3);
      u_if.instr_valid = 1'b1;
      u_if.instr = mk(2'b00, 3'd3, 3'd1, 3'd2);
      tick();
      u_if.instr_valid = 1'b0;
      wr_en = 1'b1;
      wr_addr = 3'd2;
      wr_data = 16'h1234;
      tick();
      check("wx_wb_done", 32'(done), 32'd1);
      tick();
      wr_en = 1'b0;
      read_reg(3'd2, v);
      check("wx_r2_kept", 32'(v), 32'd3);
      read_reg(3'd3, v);
      check("wx_r3", 32'(v), 32'd8);

      // same-cycle write and accept: operands see the pre-write r1
      wr_en = 1'b1;
      wr_addr = 3'd1;
      wr_data = 16'd9;
      u_if.instr_valid = 1'b1;
      u_if.instr = mk(2'b00, 3'd3, 3'd1, 3'd1);
      tick();
      wr_en = 1'b0;
      u_if.instr_valid = 1'b0;
      check("sc_exec_a", 32'(alu_a), 32'd5);
      check("sc_exec_b", 32'(alu_b), 32'd5);
      tick();
      tick();
      read_reg(3'd3, v);
      check("sc_r3", 32'(v), 32'h000A);
      read_reg(3'd1, v);
      check("sc_r1", 32'(v), 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
